// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480 timing constants, colour type and colour constants
package vga_pkg;

  localparam int H_VISIBLE  = 640;
  localparam int V_VISIBLE  = 480;
  localparam int H_TOTAL    = 800;
  localparam int V_TOTAL    = 525;
  localparam int CW         = 11;
  localparam int BLINK_LOG2 = 5;

  typedef logic [23:0] rgb_t;

  localparam rgb_t COLOR_RED   = 24'hFF0000;
  localparam rgb_t COLOR_BLACK = 24'h000000;

  function automatic logic [CW-1:0] clamp_coord(input logic [CW-1:0] val,
                                                input logic [CW-1:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// rtl/vga_pipe_delay.sv - N-stage, W-bit shift register with a parameterized reset value
module vga_pipe_delay #(
  parameter int           N       = 2,
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [N];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < N; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[N-1];

endmodule

// File: rtl/vga_box_renderer.sv
// rtl/vga_box_renderer.sv - two-stage box-over-background pixel stage with tear-free move port
// Optional blinking box compiled in with VGA_BOX_BLINK_EN.
module vga_box_renderer
  import vga_pkg::*;
#(
  parameter int   BOX_W     = 32,
  parameter int   BOX_H     = 32,
  parameter int   INIT_X    = 304,
  parameter int   INIT_Y    = 224,
  parameter rgb_t BOX_COLOR = COLOR_RED,
  parameter rgb_t BG_COLOR  = COLOR_BLACK
) (
  input  logic          clk_25,
  input  logic          reset_n,
  input  logic [CW-1:0] h_count,
  input  logic [CW-1:0] v_count,
  input  logic          h_sync_in,
  input  logic          v_sync_in,
  input  logic          move_valid,
  input  logic [CW-1:0] move_x,
  input  logic [CW-1:0] move_y,
  output logic          move_ready,
  output logic          h_sync,
  output logic          v_sync,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic          blank_n,
  output logic          frame_tick
);

  localparam logic [CW-1:0] MAX_X = CW'(H_VISIBLE - BOX_W);
  localparam logic [CW-1:0] MAX_Y = CW'(V_VISIBLE - BOX_H);

  logic [CW-1:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic [CW-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic          pend_full_q, pend_full_d;
  logic          tick_q, tick_d;
  logic          commit, transfer, shown;

  logic          vis_s1_q, hit_s1_q;
  logic          vis_c, hit_c;
  logic [11:0]   x_end_c, y_end_c;
  rgb_t          rgb_q, rgb_d;
  logic          blank_q;

  // Commit is sampled on the first blanking line so a new position never tears a frame.
  assign commit   = (h_count == '0) && (v_count == CW'(V_VISIBLE));
  assign transfer = move_valid && !pend_full_q;

  always_comb begin
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    pend_full_d = pend_full_q;
    tick_d      = commit;
    if (commit && pend_full_q) begin
      box_x_d     = pend_x_q;
      box_y_d     = pend_y_q;
      pend_full_d = 1'b0;
    end
    // A transfer only happens with the slot empty, so it never races a consuming commit.
    if (transfer) begin
      pend_x_d    = clamp_coord(move_x, MAX_X);
      pend_y_d    = clamp_coord(move_y, MAX_Y);
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      box_x_q     <= CW'(INIT_X);
      box_y_q     <= CW'(INIT_Y);
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      pend_full_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      pend_full_q <= pend_full_d;
      tick_q      <= tick_d;
    end
  end

`ifdef VGA_BOX_BLINK_EN
  logic [BLINK_LOG2:0] blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (commit) blink_d = blink_q + 1'b1;
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) blink_q <= '0;
    else          blink_q <= blink_d;
  end

  assign shown = !blink_q[BLINK_LOG2];
`else
  assign shown = 1'b1;
`endif

  // 12-bit ends: clamping keeps box_x+BOX_W <= H_VISIBLE, so no overflow.
  always_comb begin
    x_end_c = {1'b0, box_x_q} + 12'(BOX_W);
    y_end_c = {1'b0, box_y_q} + 12'(BOX_H);
    vis_c   = (h_count < CW'(H_VISIBLE)) && (v_count < CW'(V_VISIBLE));
    hit_c   = ({1'b0, h_count} >= {1'b0, box_x_q}) && ({1'b0, h_count} < x_end_c) &&
              ({1'b0, v_count} >= {1'b0, box_y_q}) && ({1'b0, v_count} < y_end_c) &&
              shown;
  end

  always_comb begin
    rgb_d = '0;
    if (vis_s1_q) rgb_d = hit_s1_q ? BOX_COLOR : BG_COLOR;
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      vis_s1_q <= 1'b0;
      hit_s1_q <= 1'b0;
      rgb_q    <= '0;
      blank_q  <= 1'b0;
    end else begin
      vis_s1_q <= vis_c;
      hit_s1_q <= hit_c;
      rgb_q    <= rgb_d;
      blank_q  <= vis_s1_q;
    end
  end

  vga_pipe_delay #(
    .N       (2),
    .W       (2),
    .RST_VAL (2'b11)
  ) u_sync_delay (
    .clk_i   (clk_25),
    .rst_n_i (reset_n),
    .d_i     ({h_sync_in, v_sync_in}),
    .q_o     ({h_sync, v_sync})
  );

  assign move_ready = !pend_full_q;
  assign frame_tick = tick_q;
  assign red        = rgb_q[23:16];
  assign green      = rgb_q[15:8];
  assign blue       = rgb_q[7:0];
  assign blank_n    = blank_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// tb/tb_vga_box_renderer.sv - table vectors plus scoreboard sequences for vga_box_renderer
module tb_vga_box_renderer;
  import vga_pkg::*;

  logic        clk_25 = 1'b0;
  logic        reset_n;
  logic [10:0] h_count, v_count, move_x, move_y;
  logic        h_sync_in, v_sync_in, move_valid;
  logic        move_ready, h_sync, v_sync, blank_n, frame_tick;
  logic [7:0]  red, green, blue;

  always #20 clk_25 = ~clk_25;

  vga_box_renderer dut (
    .clk_25     (clk_25),
    .reset_n    (reset_n),
    .h_count    (h_count),
    .v_count    (v_count),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .move_valid (move_valid),
    .move_x     (move_x),
    .move_y     (move_y),
    .move_ready (move_ready),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .blank_n    (blank_n),
    .frame_tick (frame_tick)
  );

  typedef struct {
    logic [23:0] rgb;
    logic        blank;
    logic        hs;
    logic        vs;
  } exp_t;

  typedef struct {
    int          h;
    int          v;
    logic [23:0] rgb;
    logic        blank;
  } vec_t;

  exp_t sb[$];
  vec_t tab[12];
  int   checks = 0;
  int   errors = 0;

  int   m_bx, m_by, m_px, m_py, m_blink;
  bit   m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [23:0] model_rgb(input int h, input int v);
    bit vis, hit, shown;
    vis   = (h < 640) && (v < 480);
    shown = 1'b1;
`ifdef VGA_BOX_BLINK_EN
    shown = ((m_blink / 32) % 2) == 0;
`endif
    hit = (h >= m_bx) && (h < m_bx + 32) && (v >= m_by) && (v < m_by + 32) && shown;
    if (!vis) return 24'h000000;
    return hit ? 24'hFF0000 : 24'h000000;
  endfunction

  task automatic step(input int h, input int v, input logic hs, input logic vs,
                      input logic mv, input int mx, input int my,
                      input bit use_tab, input logic [23:0] t_rgb, input logic t_blank);
    exp_t e, got;
    bit   commit, tr;
    @(negedge clk_25);
    h_count    = 11'(h);
    v_count    = 11'(v);
    h_sync_in  = hs;
    v_sync_in  = vs;
    move_valid = mv;
    move_x     = 11'(mx);
    move_y     = 11'(my);
    if (use_tab) begin
      e.rgb   = t_rgb;
      e.blank = t_blank;
    end else begin
      e.rgb   = model_rgb(h, v);
      e.blank = (h < 640) && (v < 480);
    end
    e.hs = hs;
    e.vs = vs;
    sb.push_back(e);
    commit = (h == 0) && (v == 480);
    tr     = mv && !m_pend;
    if (commit) begin
      if (m_pend) begin
        m_bx   = m_px;
        m_by   = m_py;
        m_pend = 1'b0;
      end
      m_blink++;
    end
    if (tr) begin
      m_px   = (mx > 608) ? 608 : mx;
      m_py   = (my > 448) ? 448 : my;
      m_pend = 1'b1;
    end
    @(posedge clk_25);
    #1;
    check("frame_tick", frame_tick, commit);
    check("move_ready", move_ready, !m_pend);
    if (sb.size() == 2) begin
      got = sb.pop_front();
      check("rgb", {red, green, blue}, got.rgb);
      check("blank_sync", {blank_n, h_sync, v_sync}, {got.blank, got.hs, got.vs});
    end
  endtask

  task automatic px(input int h, input int v);
    step(h, v, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic offer(input int h, input int v, input int mx, input int my);
    step(h, v, 1'b1, 1'b1, 1'b1, mx, my, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_25);
    reset_n    = 1'b0;
    move_valid = 1'b0;
    h_count    = 11'd1;
    v_count    = 11'd1;
    h_sync_in  = 1'b1;
    v_sync_in  = 1'b1;
    sb.delete();
    m_bx    = 304;
    m_by    = 224;
    m_pend  = 1'b0;
    m_blink = 0;
    @(posedge clk_25);
    #1;
    check("rst_rgb", {red, green, blue}, 24'h0);
    check("rst_blank", blank_n, 1'b0);
    check("rst_hsync", h_sync, 1'b1);
    check("rst_vsync", v_sync, 1'b1);
    check("rst_ready", move_ready, 1'b1);
    check("rst_tick", frame_tick, 1'b0);
    @(negedge clk_25);
    reset_n = 1'b1;
  endtask

  initial begin
    int lows, first;
    lows  = 0;
    first = -1;
    reset_n = 1'b0; move_valid = 1'b0; move_x = '0; move_y = '0;
    h_count = '0; v_count = '0; h_sync_in = 1'b1; v_sync_in = 1'b1;

    tab[0]  = '{304, 224, 24'hFF0000, 1'b1};
    tab[1]  = '{335, 255, 24'hFF0000, 1'b1};
    tab[2]  = '{320, 240, 24'hFF0000, 1'b1};
    tab[3]  = '{303, 224, 24'h000000, 1'b1};
    tab[4]  = '{336, 240, 24'h000000, 1'b1};
    tab[5]  = '{304, 223, 24'h000000, 1'b1};
    tab[6]  = '{310, 256, 24'h000000, 1'b1};
    tab[7]  = '{0,   0,   24'h000000, 1'b1};
    tab[8]  = '{639, 479, 24'h000000, 1'b1};
    tab[9]  = '{640, 100, 24'h000000, 1'b0};
    tab[10] = '{100, 480, 24'h000000, 1'b0};
    tab[11] = '{799, 524, 24'h000000, 1'b0};

    do_reset();

    for (int i = 0; i < 12; i++)
      step(tab[i].h, tab[i].v, i[0], i[1], 1'b0, 0, 0, 1'b1, tab[i].rgb, tab[i].blank);
    px(2, 2);

    // hsync: low for h 656..751, observed two cycles later
    for (int h = 600; h < 800; h++) begin
      step(h, 10, !((h >= 656) && (h < 752)), 1'b1, 1'b0, 0, 0, 1'b0, 24'h0, 1'b0);
      if (!h_sync) begin
        lows++;
        if (first < 0) first = h;
      end
    end
    px(0, 11);
    if (!h_sync) lows++;
    check("hsync_low_len", lows, 96);
    check("hsync_first", first, 657);

    for (int v = 486; v < 495; v++)
      for (int h = 0; h < 2; h++)
        step(h, v, 1'b1, !((v == 490) || (v == 491)), 1'b0, 0, 0, 1'b0, 24'h0, 1'b0);

    // clamped move taken mid-frame, shown only after commit
    offer(100, 100, 700, 470);
    px(304, 224); px(620, 460);
    px(0, 480);
    px(608, 448); px(639, 479); px(304, 224); px(607, 448); px(1, 1);

    // held offers: one transfer per frame
    for (int i = 0; i < 3; i++) offer(50, 50, 100, 50);
    for (int i = 0; i < 3; i++) offer(51, 50, 200, 60);
    offer(0, 480, 200, 60);
    offer(5, 5, 200, 60);
    px(100, 50); px(200, 60);
    px(0, 480);
    px(200, 60); px(231, 91); px(100, 50); px(1, 1);

    // offer in the commit cycle with the slot empty
    offer(0, 480, 10, 20);
    px(200, 60); px(10, 20);
    px(0, 480);
    px(10, 20); px(41, 51); px(42, 51); px(1, 1);

    // reset with pending full
    offer(7, 7, 400, 300);
    do_reset();
    px(304, 224); px(400, 300);
    px(0, 480);
    px(304, 224); px(400, 300); px(1, 1);

`ifdef VGA_BOX_BLINK_EN
    while (m_blink < 32) px(0, 480);
    px(304, 224); px(1, 1);
    check("blink_hidden", {red, green, blue}, 24'h000000);
    while (m_blink < 64) px(0, 480);
    px(304, 224); px(1, 1);
    check("blink_shown", {red, green, blue}, 24'hFF0000);
`endif

    px(1, 1); px(1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_box_renderer.md
# vga_box_renderer

Pixel-colour stage placed directly after the 640x480@60 Hz horizontal/vertical counter. It takes the raw pixel coordinates and sync signals and produces registered 24-bit RGB, blank and sync outputs for the VGA DAC, with syncs delayed to match the pixel pipeline. It draws one movable solid box over a background colour. A ready/valid port accepts position updates, which take effect only at the start of vertical blanking so a frame never tears.

## Interface
- H_VISIBLE, 640, visible pixels per line
- V_VISIBLE, 480, visible lines per frame
- BOX_W, 32, box width in pixels
- BOX_H, 32, box height in lines
- INIT_X, 304, box left edge after reset
- INIT_Y, 224, box top edge after reset
- BOX_COLOR, 24'hFF0000, box RGB888
- BG_COLOR, 24'h000000, background RGB888
- BLINK_LOG2, 5, blink half-period is 2^BLINK_LOG2 frames (used only when blink is compiled in)

Ports, in order name / direction / width / meaning:
- clk_25  in  1  25 MHz pixel clock
- reset_n  in  1  asynchronous, active-low reset
- h_count  in  11  current pixel x from the counter
- v_count  in  11  current pixel y from the counter
- h_sync_in  in  1  active-low hsync from the counter
- v_sync_in  in  1  active-low vsync from the counter
- move_valid  in  1  new position offered
- move_x  in  11  requested left edge
- move_y  in  11  requested top edge
- move_ready  out  1  pending slot empty; offer can be taken
- h_sync  out  1  delayed hsync to connector
- v_sync  out  1  delayed vsync to connector
- red, green, blue  out  8 each  pixel colour
- blank_n  out  1  high when the output pixel is visible
- frame_tick  out  1  one-cycle pulse when a position is committed

## Operation
- Two-stage pipeline.
  - S1 registers h_count, v_count and the syncs, and computes `visible = h<H_VISIBLE && v<V_VISIBLE`.
  - S1 also computes `hit = h>=box_x && h<box_x+BOX_W && v>=box_y && v<box_y+BOX_H`. Compares are 12-bit; a sum cannot overflow because of clamping.
  - S2 registers the outputs. Colour is BOX_COLOR if visible&&hit&&shown, BG_COLOR if visible and not a hit, and 0 if not visible. blank_n = visible.
- Position handshake:
  - One pending slot; move_ready = !pending_full.
  - A transfer occurs when move_valid && move_ready. It stores the clamped values `min(move_x, H_VISIBLE-BOX_W)` and `min(move_y, V_VISIBLE-BOX_H)` and sets pending_full.
  - The commit point is the sampled cycle where `h_count==0 && v_count==V_VISIBLE`.
  - At commit, if pending_full: box_x/box_y take the pending values, pending_full clears, and frame_tick pulses. If the slot is empty, position is unchanged and frame_tick still pulses.
- Simultaneous transfer and commit:
  - Only possible with the slot empty. The commit keeps the old position, and the new value lands in pending for the next frame.
- Reset (including mid-frame or mid-handshake):
  - pending is discarded; box_x=INIT_X, box_y=INIT_Y.
  - h_sync=1, v_sync=1, RGB=0, blank_n=0, move_ready=1, frame_tick=0.
  - The pipeline is flushed to these values.

## Timing
- RGB, blank_n, h_sync and v_sync have a fixed latency of 2 clk_25 cycles from h_count/v_count/h_sync_in/v_sync_in. The skew between them is 0.
- A committed position affects pixels sampled from the cycle after the commit. That is always inside blanking, so it first shows on line 0 of the next frame.
- frame_tick is high for exactly the one cycle after the commit sample. The box registers update on that same edge.
- move_ready falls on the edge after a transfer and rises on the edge after a commit that consumed the slot.
- The counter wraps at 799/524 with no special handling.

## Configuration
- VGA_BOX_BLINK_EN defined:
  - A BLINK_LOG2+1-bit frame counter increments on every commit point.
  - shown = !counter[BLINK_LOG2], so the box is visible for 32 frames and then hidden for 32.
  - The counter resets to 0, so the box is shown after reset.
- VGA_BOX_BLINK_EN undefined: no counter, shown = 1 always.

## Structure
- Shared package vga_pkg holds:
  - timing constants H_VISIBLE=640, V_VISIBLE=480, H_TOTAL=800, V_TOTAL=525;
  - the 24-bit rgb_t type;
  - the named colour constants.
- Sub-module vga_pipe_delay: a parameterized N-stage, W-bit async-reset shift register. Here it is instantiated with N=2 for the syncs; its reset value is a parameter (all-ones for syncs).

## Test plan
- Reset, then one full frame with default position → red only at x 304..335 and y 224..255, black elsewhere. blank_n low for x>=640 or y>=480. RGB=0 in blanking.
- Latency check → h_sync low for exactly the 96 cycles starting 2 cycles after h_count reaches 656. v_sync low on lines 490–491, shifted by 2 cycles.
- move_x=700, move_y=470 mid-frame → ready drops. The current frame is unchanged. Commit clamps to (608,448). The next frame shows the box at x 608..639, y 448..479. frame_tick pulses once.
- Hold move_valid continuously with new values → exactly one transfer per frame. The second offer waits until ready rises after the commit.
- Offer a move in the exact commit cycle with the slot empty → no position change this frame; the change applies at the following commit.
- Assert reset_n low mid-handshake with pending full → move_ready=1 and position back at (304,224). With VGA_BOX_BLINK_EN, the box is hidden on frames 32–63 after reset.
